// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file writeback arbiter slice.
//   XLEN_DEF / AW_DEF : default data and register-address widths of the register file
//   wb_beat_t         : one writeback beat (destination register + write data)
//   is_x0()           : true when a destination address names the hard-wired zero register
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    typedef struct packed {
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
    } wb_beat_t;

    // x0 is hard-wired to zero, so beats aimed at it are accepted but never written.
    function automatic logic is_x0(input logic [AW_DEF-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter
// Combinational rotating-priority arbiter. The search starts at index ptr and wraps
// around, so the first requester at or after ptr wins. Tying ptr to zero turns it into
// a fixed lowest-index-wins arbiter. The pointer register itself lives in the parent.
// Ports:
//   req     in   NREQ   request vector
//   ptr     in   PW     index that currently has highest priority
//   gnt     out  NREQ   one-hot grant, all-zero when req is all-zero
//   gnt_idx out  PW     binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx
);

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between NREQ writeback sources.
// One valid/ready beat is accepted per cycle and presented on we3/wa3/wd3 the
// following cycle through a registered output stage.
// Build option: define WB_ARB_RR_EN for round-robin arbitration with a rotating
// pointer; leave it undefined for fixed priority (lowest index wins, no pointer).
// Ports:
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous reset, active-low
//   req_valid  in   NREQ       requester i has a write pending
//   req_addr   in   NREQ*AW    destination register of requester i (slice i*AW)
//   req_data   in   NREQ*XLEN  write data of requester i (slice i*XLEN)
//   req_ready  out  NREQ       one-hot or zero; requester i's beat accepted this cycle
//   flush      in   1          pipeline flush; blocks acceptance this cycle
//   we3        out  1          register file write enable
//   wa3        out  AW         register file write address
//   wd3        out  XLEN       register file write data
//   wb_busy    out  1          any req_valid bit high (combinational)
// XLEN and AW must match the register file, whose widths are the package defaults.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [XLEN-1:0]      wd3,
    output logic                 wb_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   arb_ptr;
    logic            accept;
    wb_beat_t        sel_beat;
    wb_beat_t        beat_d, beat_q;
    logic            we_d, we_q;

`ifdef WB_ARB_RR_EN
    logic [PW-1:0]   ptr_d, ptr_q;
    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = '0;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (arb_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The register file never backpressures, so the arbiter's pick is accepted
    // unless a flush or reset suppresses the handshake this cycle.
    assign req_ready = (rst && !flush) ? gnt : '0;
    assign accept    = |req_ready;
    assign wb_busy   = |req_valid;

    assign sel_beat.addr = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_beat.data = req_data[int'(gnt_idx)*XLEN +: XLEN];

    // Output stage loads the accepted beat; x0 beats keep their addr/data visible
    // but never raise the write enable. Without acceptance the enable drops.
    always_comb begin
        we_d   = 1'b0;
        beat_d = beat_q;
        if (accept) begin
            we_d   = !is_x0(sel_beat.addr);
            beat_d = sel_beat;
        end
    end

`ifdef WB_ARB_RR_EN
    // Pointer moves just past the winner, wrapping at NREQ-1; it holds on idle/flush.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q   <= 1'b0;
            beat_q <= '0;
        end else begin
            we_q   <= we_d;
            beat_q <= beat_d;
        end
    end

    assign we3 = we_q;
    assign wa3 = beat_q.addr;
    assign wd3 = beat_q.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. Two instances share clock, reset and
// flush: dut (NREQ=2) for the main scenarios and dut3 (NREQ=3) for pointer wrap.
// A behavioural model predicts ready/busy/write-port values each cycle; directed
// literal checks pin the model to hand-computed results.
module tb_regfile_wb_arbiter;

`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic [1:0]  v2;
    logic [9:0]  a2;
    logic [63:0] d2;
    logic [1:0]  rdy2;
    logic        we2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
    logic        busy2;

    logic [2:0]  v3;
    logic [14:0] a3;
    logic [95:0] d3;
    logic [2:0]  rdy3;
    logic        we3_3;
    logic [4:0]  wa3_3;
    logic [31:0] wd3_3;
    logic        busy3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst(rst), .req_valid(v2), .req_addr(a2), .req_data(d2),
        .req_ready(rdy2), .flush(flush), .we3(we2), .wa3(wa2), .wd3(wd2),
        .wb_busy(busy2)
    );

    regfile_wb_arbiter #(.NREQ(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_addr(a3), .req_data(d3),
        .req_ready(rdy3), .flush(flush), .we3(we3_3), .wa3(wa3_3), .wd3(wd3_3),
        .wb_busy(busy3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and drive the control inputs.
    task automatic applyStimulus(input logic r, input logic f,
                                 input logic [1:0] nv2, input logic [2:0] nv3);
        @(posedge clk);
        #1;
        rst   = r;
        flush = f;
        v2    = nv2;
        v3    = nv3;
    endtask

    // Model: which requester wins, given valid bits, requester count and pointer.
    function automatic int model_grant(input logic [7:0] v, input int n, input int p,
                                       input logic fl, input logic rs);
        int i;
        if (!rs || fl) return -1;
        for (int k = 0; k < n; k++) begin
            i = RR ? (p + k) % n : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    int          m_ptr2 = 0, m_ptr3 = 0;
    logic        m_we2 = 0, m_we3 = 0;
    logic        m_bt2 = 0, m_bt3 = 0;
    logic [4:0]  m_wa2 = 0, m_wa3 = 0;
    logic [31:0] m_wd2 = 0, m_wd3 = 0;

    // Model state advance: a beat granted before an edge appears on the port after it.
    always @(posedge clk) begin
        int g;
        if (!rst) begin
            m_ptr2 = 0; m_ptr3 = 0; m_we2 = 0; m_we3 = 0; m_bt2 = 0; m_bt3 = 0;
            m_wa2 = 0; m_wa3 = 0; m_wd2 = 0; m_wd3 = 0;
        end else begin
            g = model_grant(8'(v2), 2, m_ptr2, flush, rst);
            m_bt2 = (g >= 0);
            m_we2 = 0;
            if (g >= 0) begin
                m_wa2 = a2[g*5 +: 5];
                m_wd2 = d2[g*32 +: 32];
                m_we2 = (m_wa2 != 0);
                if (RR) m_ptr2 = (g + 1) % 2;
            end
            g = model_grant(8'(v3), 3, m_ptr3, flush, rst);
            m_bt3 = (g >= 0);
            m_we3 = 0;
            if (g >= 0) begin
                m_wa3 = a3[g*5 +: 5];
                m_wd3 = d3[g*32 +: 32];
                m_we3 = (m_wa3 != 0);
                if (RR) m_ptr3 = (g + 1) % 3;
            end
        end
    end

    // Compare process: mid-cycle check of every output against the model.
    always @(negedge clk) begin
        int g;
        logic [7:0] e;
        g = model_grant(8'(v2), 2, m_ptr2, flush, rst);
        e = (g >= 0) ? 8'(1 << g) : 8'h0;
        checkOutput("m2_ready", 32'(rdy2), 32'(e));
        checkOutput("m2_busy", 32'(busy2), 32'(|v2));
        checkOutput("m2_we", 32'(we2), 32'(m_we2));
        if (m_bt2) begin
            checkOutput("m2_wa", 32'(wa2), 32'(m_wa2));
            checkOutput("m2_wd", wd2, m_wd2);
        end
        g = model_grant(8'(v3), 3, m_ptr3, flush, rst);
        e = (g >= 0) ? 8'(1 << g) : 8'h0;
        checkOutput("m3_ready", 32'(rdy3), 32'(e));
        checkOutput("m3_busy", 32'(busy3), 32'(|v3));
        checkOutput("m3_we", 32'(we3_3), 32'(m_we3));
        if (m_bt3) begin
            checkOutput("m3_wa", 32'(wa3_3), 32'(m_wa3));
            checkOutput("m3_wd", wd3_3, m_wd3);
        end
    end

    logic [1:0] exp_gnt[4];
    logic [4:0] exp_wa[4];
    logic [2:0] exp_gnt3[4];

    initial begin
`ifdef WB_ARB_RR_EN
        exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_wa   = '{5'd1, 5'd2, 5'd1, 5'd2};
        exp_gnt3 = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_gnt  = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_wa   = '{5'd1, 5'd1, 5'd1, 5'd1};
        exp_gnt3 = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        rst = 1'b0; flush = 1'b0;
        v2 = 2'b11; a2 = {5'd2, 5'd1}; d2 = {32'hBBBB_0002, 32'hAAAA_0001};
        v3 = 3'b000; a3 = '0; d3 = '0;

        // Reset held two cycles with both requesters valid.
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_ready", 32'(rdy2), 32'h0);
            checkOutput("rst_we", 32'(we2), 32'h0);
        end
        checkOutput("rst_wa", 32'(wa2), 32'h0);
        checkOutput("rst_wd", wd2, 32'h0);

        // Release and contend for four cycles.
        applyStimulus(1'b1, 1'b0, 2'b11, 3'b000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("contend_ready", 32'(rdy2), 32'(exp_gnt[k]));
            if (k > 0) begin
                checkOutput("contend_we", 32'(we2), 32'h1);
                checkOutput("contend_wa", 32'(wa2), 32'(exp_wa[k-1]));
            end
            if (k < 3) applyStimulus(1'b1, 1'b0, 2'b11, 3'b000);
        end
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        @(negedge clk);
        checkOutput("contend_last_wa", 32'(wa2), 32'(exp_wa[3]));
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        @(negedge clk);
        checkOutput("idle_we", 32'(we2), 32'h0);

        // Single beat from requester 0.
        applyStimulus(1'b1, 1'b0, 2'b01, 3'b000);
        a2 = {5'd2, 5'd5}; d2 = {32'hBBBB_0002, 32'hDEAD_BEEF};
        @(negedge clk);
        checkOutput("single_ready", 32'(rdy2), 32'h1);
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        @(negedge clk);
        checkOutput("single_we", 32'(we2), 32'h1);
        checkOutput("single_wa", 32'(wa2), 32'd5);
        checkOutput("single_wd", wd2, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        @(negedge clk);
        checkOutput("single_we_off", 32'(we2), 32'h0);

        // Beat to x0 from requester 1.
        applyStimulus(1'b1, 1'b0, 2'b10, 3'b000);
        a2 = {5'd0, 5'd5}; d2 = {32'h0000_1234, 32'hDEAD_BEEF};
        @(negedge clk);
        checkOutput("x0_ready", 32'(rdy2), 32'h2);
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        @(negedge clk);
        checkOutput("x0_we", 32'(we2), 32'h0);
        checkOutput("x0_wa", 32'(wa2), 32'h0);
        checkOutput("x0_wd", wd2, 32'h0000_1234);

        // Flush right after an accepted beat.
        applyStimulus(1'b1, 1'b0, 2'b01, 3'b000);
        a2 = {5'd4, 5'd7}; d2 = {32'h4444_4444, 32'h7777_7777};
        @(negedge clk);
        checkOutput("flush_pre_ready", 32'(rdy2), 32'h1);
        applyStimulus(1'b1, 1'b1, 2'b11, 3'b000);
        a2 = {5'd4, 5'd3};
        @(negedge clk);
        checkOutput("flush_ready", 32'(rdy2), 32'h0);
        checkOutput("flush_we", 32'(we2), 32'h1);
        checkOutput("flush_wa", 32'(wa2), 32'd7);
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        @(negedge clk);
        checkOutput("flush_after_we", 32'(we2), 32'h0);

        // Three requesters, pointer wrap on dut3.
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        a3 = {5'd3, 5'd2, 5'd1};
        d3 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("wrap_ready", 32'(rdy3), 32'(exp_gnt3[k]));
            if (k == 2) applyStimulus(1'b1, 1'b0, 2'b00, 3'b001);
            else if (k < 2) applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        end
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        @(negedge clk);
        checkOutput("wrap_wa", 32'(wa3_3), 32'd1);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
